// File: rtl/adc_serial_capture.sv
// adc_serial_capture: reads one conversion from N_CH serial ADCs
// per strobe and emits one stream beat per channel.
module adc_serial_capture #(
  parameter int N_CH      = 8,
  parameter int DATA_BITS = 18,
  parameter int CONV_WAIT = 4,
  parameter int SCLK_HALF = 1
) (
  input  logic                 clk_100,
  input  logic                 rst,
  input  logic                 acq_en,
  input  logic                 adc_start_conv_n,
  input  logic [N_CH-1:0]      adc_sdata,
  output logic                 adc_sclk,
  output logic [DATA_BITS-1:0] m_tdata,
  output logic [3:0]           m_tuser,
  output logic                 m_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [31:0]          frame_cnt,
  output logic [15:0]          overrun_cnt,
  output logic                 overrun
);

  localparam int WW = (CONV_WAIT > 1) ? $clog2(CONV_WAIT) : 1;
  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_EMIT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          start_q;
  logic [WW-1:0] wait_q;
  logic [HW-1:0] half_q;
  logic [BW-1:0] bit_q;
  logic          sclk_q;
  logic [3:0]    ch_q;
  logic          valid_q;
  logic [31:0]   frame_q;
  logic [15:0]   ovr_q;
  logic          ovr_flag_q;
  logic [15:0]   lane;

  logic [15:0][DATA_BITS-1:0] shreg;

  logic trig;
  logic wait_done;
  logic half_done;
  logic bit_done;
  logic sample;
  logic beat;
  logic last_ch;
  logic fin;

  assign lane      = 16'(adc_sdata);
  assign trig      = adc_start_conv_n & ~start_q;
  assign wait_done = (wait_q == WW'(CONV_WAIT - 1));
  assign half_done = (half_q == HW'(SCLK_HALF - 1));
  assign bit_done  = (bit_q == BW'(DATA_BITS - 1));
  assign sample    = (state_q == S_SHIFT) & half_done & sclk_q;
  assign beat      = valid_q & m_tready;
  assign last_ch   = (ch_q == 4'(N_CH - 1));
  assign fin       = beat & last_ch;

  // Next-state decode of the readout sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (trig && acq_en) state_d = S_WAIT;
      S_WAIT:  if (wait_done) state_d = S_SHIFT;
      S_SHIFT: if (sample && bit_done) state_d = S_EMIT;
      S_EMIT:  if (fin) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_100) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Strobe edge detect; idles high so reset never fakes a release.
  always_ff @(posedge clk_100) begin
    if (rst) start_q <= 1'b1;
    else     start_q <= adc_start_conv_n;
  end

  // Conversion wait timer and serial clock / bit counters.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      wait_q <= '0;
      half_q <= '0;
      bit_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      if (state_q != S_WAIT)
        wait_q <= '0;
      else if (!wait_done)
        wait_q <= wait_q + 1'b1;
      if (state_q == S_SHIFT) begin
        if (half_done) begin
          half_q <= '0;
          sclk_q <= ~sclk_q;
          if (sclk_q) bit_q <= bit_q + 1'b1;
        end else begin
          half_q <= half_q + 1'b1;
        end
      end else begin
        half_q <= '0;
        bit_q  <= '0;
        sclk_q <= 1'b0;
      end
    end
  end

  // Per-lane deserialisers, MSB first, sampled at end of sclk high.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      shreg <= '0;
    end else if (sample) begin
      for (int i = 0; i < 16; i++) begin
        if (i < N_CH)
          shreg[i] <= {shreg[i][DATA_BITS-2:0], lane[i]};
      end
    end
  end

  // Beat sequencing: channel index advances only on handshake.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      valid_q <= 1'b0;
      ch_q    <= '0;
    end else if (sample && bit_done) begin
      valid_q <= 1'b1;
      ch_q    <= '0;
    end else if (fin) begin
      valid_q <= 1'b0;
      ch_q    <= '0;
    end else if (beat) begin
      ch_q <= ch_q + 1'b1;
    end
  end

  // Frame and overrun status counters.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      frame_q    <= '0;
      ovr_q      <= '0;
      ovr_flag_q <= 1'b0;
    end else begin
      if (fin) frame_q <= frame_q + 1'b1;
      if (trig && state_q == S_EMIT) begin
        ovr_flag_q <= 1'b1;
        if (ovr_q != 16'hFFFF) ovr_q <= ovr_q + 1'b1;
      end
    end
  end

  assign adc_sclk    = sclk_q;
  assign m_tvalid    = valid_q;
  assign m_tuser     = ch_q;
  assign m_tlast     = valid_q & last_ch;
  assign m_tdata     = shreg[ch_q];
  assign frame_cnt   = frame_q;
  assign overrun_cnt = ovr_q;
  assign overrun     = ovr_flag_q;

endmodule
